uart_tx_buffered: RTL and testbench

- Buffered UART transmitter between the memory-access stage's MMIO store path and the board's serial TX pin.
- Accepts byte writes into a FIFO and serializes them as 8N1 frames at a fixed baud, so back-to-back stores from the pipeline are not lost while a frame is in flight.
- Exposes full/busy status so the Controller can stall stores and software can poll for drain.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/uart_tx_buffered.sv | 153 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the buffered UART transmitter.
//             Holds the serializer state encoding, the default baud divisor
//             and the MMIO addresses the memory-access stage decodes.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

    // 100 MHz system clock / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    // MMIO map: byte stores to the data register enqueue a character,
    // loads from the status register return {overflow, busy, full, empty}.
    localparam logic [31:0] UART_DATA_ADDR   = 32'h1000_0000;
    localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_0004;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with occupancy count. Writes into a full FIFO
//             and reads from an empty FIFO are ignored. Read data is the head
//             entry, visible combinationally (first-word fall-through).
//  Ports    : i_clk, i_rst_n  - clock, async active-low reset
//             i_push, i_wdata - write strobe and data
//             i_pop, o_rdata  - read strobe and head data
//             o_count         - occupancy, 0..DEPTH
//             o_full, o_empty - decoded from the registered count
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Full is judged on the registered count only, so a pop in the same
    // cycle never makes room for a write.
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is natural overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffered
//  Purpose  : Buffered 8N1 UART transmitter. Byte stores are queued in a
//             FIFO and serialized LSB first at CLKS_PER_BIT clocks per bit.
//  Ports    : sys_clk_i, sys_rstn_i - clock, async active-low reset
//             wr_i, dat_i           - byte write strobe and data
//             full_o, empty_o       - FIFO status
//             busy_o                - frame in flight or bytes queued
//             count_o               - FIFO occupancy
//             overflow_o, ovf_clr_i - sticky dropped-write flag and its clear
//             uart_tx_o             - registered serial line, idle high
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DEPTH        = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rstn_i,
    input  logic                   wr_i,
    input  logic [7:0]             dat_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    input  logic                   ovf_clr_i,
    output logic                   uart_tx_o
);

    localparam int BW = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam logic [BW-1:0] c_BIT_END  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] c_STOP_END = BW'(CLKS_PER_BIT * STOP_BITS - 1);

    uart_tx_state_e r_state, w_state_nx;
    logic [BW-1:0]  r_bcnt,  w_bcnt_nx;
    logic [7:0]     r_shift, w_shift_nx;
    logic [2:0]     r_idx,   w_idx_nx;
    logic           r_tx,    w_tx_nx;
    logic           r_ovf;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [7:0]     w_rdata;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (sys_clk_i),
        .i_rst_n (sys_rstn_i),
        .i_push  (wr_i),
        .i_wdata (dat_i),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (count_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign full_o     = w_full;
    assign empty_o    = w_empty;
    assign busy_o     = (r_state != IDLE) | ~w_empty;
    assign overflow_o = r_ovf;
    assign uart_tx_o  = r_tx;

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_bcnt  <= w_bcnt_nx;
            r_shift <= w_shift_nx;
            r_idx   <= w_idx_nx;
            r_tx    <= w_tx_nx;
        end
    end

    // A dropped write outranks a clear in the same cycle so no loss goes
    // unreported.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_ovf <= 1'b0;
        end else if (wr_i && w_full) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr_i) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_bcnt_nx  = r_bcnt + BW'(1);
        w_shift_nx = r_shift;
        w_idx_nx   = r_idx;
        w_tx_nx    = r_tx;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_bcnt_nx = '0;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_rdata;
                    w_tx_nx    = 1'b0;
                    w_state_nx = START;
                end else begin
                    w_tx_nx = 1'b1;
                end
            end
            START: begin
                if (r_bcnt == c_BIT_END) begin
                    w_bcnt_nx  = '0;
                    w_tx_nx    = r_shift[0];
                    w_idx_nx   = '0;
                    w_state_nx = DATA;
                end
            end
            DATA: begin
                if (r_bcnt == c_BIT_END) begin
                    w_bcnt_nx = '0;
                    if (r_idx == 3'd7) begin
                        w_tx_nx    = 1'b1;
                        w_state_nx = STOP;
                    end else begin
                        // Next bit is the one about to land in shift[0].
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_tx_nx    = r_shift[1];
                        w_idx_nx   = r_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (r_bcnt == c_STOP_END) begin
                    w_bcnt_nx  = '0;
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

endmodule : uart_tx_buffered
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_buffered
//  Purpose  : Self-checking bench for uart_tx_buffered (CLKS_PER_BIT=4,
//             DEPTH=4, STOP_BITS=1). A frame-level reference model (byte
//             queue plus elapsed-time-into-frame) predicts every output each
//             cycle; directed sequences and a vector table cover corners.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEP   = 4;
    localparam int STB   = 1;
    localparam int FRAME = (10 + STB - 1) * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_i = 1'b0;
    logic [7:0] dat_i = 8'h00;
    logic       ovf_clr_i = 1'b0;
    logic       full_o, empty_o, busy_o, overflow_o, uart_tx_o;
    logic [2:0] count_o;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEP),
        .STOP_BITS    (STB)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rstn_i (rst_n),
        .wr_i       (wr_i),
        .dat_i      (dat_i),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .busy_o     (busy_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .ovf_clr_i  (ovf_clr_i),
        .uart_tx_o  (uart_tx_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    logic [7:0] m_cur = 8'h00;
    int         m_t = 0;
    bit         m_ovf = 1'b0;

    function automatic void m_reset();
        mq.delete();
        m_active = 1'b0;
        m_t      = 0;
        m_ovf    = 1'b0;
    endfunction

    // Line level from time elapsed into the frame: start, 8 data, stop.
    function automatic logic m_line();
        int b;
        if (!m_active) return 1'b1;
        b = m_t / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    function automatic void m_edge(input bit wr, input logic [7:0] d, input bit clr);
        bit full_pre;
        bit empty_pre;
        full_pre  = (mq.size() == DEP);
        empty_pre = (mq.size() == 0);
        if (m_active) begin
            m_t++;
            if (m_t == FRAME) m_active = 1'b0;
        end else if (!empty_pre) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_t      = 0;
        end
        if (wr && !full_pre) mq.push_back(d);
        if (wr && full_pre) m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic cmp_model();
        chk("tx",    {31'd0, uart_tx_o},  {31'd0, m_line()});
        chk("count", {29'd0, count_o},    mq.size());
        chk("full",  {31'd0, full_o},     {31'd0, mq.size() == DEP});
        chk("empty", {31'd0, empty_o},    {31'd0, mq.size() == 0});
        chk("busy",  {31'd0, busy_o},     {31'd0, m_active || mq.size() != 0});
        chk("ovf",   {31'd0, overflow_o}, {31'd0, m_ovf});
    endtask

    task automatic step(input bit wr, input logic [7:0] d, input bit clr);
        wr_i      = wr;
        dat_i     = d;
        ovf_clr_i = clr;
        @(posedge clk);
        m_edge(wr, d, clr);
        #1;
        wr_i      = 1'b0;
        ovf_clr_i = 1'b0;
        cmp_model();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((m_active || mq.size() != 0) && n < limit) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("drain_bound", {31'd0, (m_active || mq.size() != 0)}, 32'd0);
        step(1'b0, 8'h00, 1'b0);
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] d;
        bit         clr;
        logic [2:0] cnt;
        bit         full;
        bit         ovf;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [9:0] samp;
        logic [9:0] exp_a5;
        int         busy_drop;
        int         n;
        int         rate;

        // Bytes 01..05 back to back, FF into a full FIFO, clear+write, clear.
        vt[0] = '{1'b1, 8'h01, 1'b0, 3'd1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 8'h02, 1'b0, 3'd1, 1'b0, 1'b0};
        vt[2] = '{1'b1, 8'h03, 1'b0, 3'd2, 1'b0, 1'b0};
        vt[3] = '{1'b1, 8'h04, 1'b0, 3'd3, 1'b0, 1'b0};
        vt[4] = '{1'b1, 8'h05, 1'b0, 3'd4, 1'b1, 1'b0};
        vt[5] = '{1'b1, 8'hFF, 1'b0, 3'd4, 1'b1, 1'b1};
        vt[6] = '{1'b1, 8'hAA, 1'b1, 3'd4, 1'b1, 1'b1};
        vt[7] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0};
        vt[8] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0};

        // ---- reset and idle ----
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx",    {31'd0, uart_tx_o},  32'd1);
        chk("rst_empty", {31'd0, empty_o},    32'd1);
        chk("rst_busy",  {31'd0, busy_o},     32'd0);
        chk("rst_count", {29'd0, count_o},    32'd0);
        chk("rst_full",  {31'd0, full_o},     32'd0);
        chk("rst_ovf",   {31'd0, overflow_o}, 32'd0);
        rst_n = 1'b1;
        repeat (50) step(1'b0, 8'h00, 1'b0);

        // ---- single 0xA5 frame: start latency, bit centres, busy length ----
        exp_a5 = 10'b1101001010;
        samp   = '0;
        busy_drop = -1;
        step(1'b1, 8'hA5, 1'b0);
        chk("a5_tx_k", {31'd0, uart_tx_o}, 32'd1);
        for (int j = 1; j <= 45; j++) begin
            step(1'b0, 8'h00, 1'b0);
            if (j == 1) chk("a5_tx_k1", {31'd0, uart_tx_o}, 32'd0);
            if (j >= 3 && j <= 39 && ((j - 3) % 4) == 0) samp[(j - 3) / 4] = uart_tx_o;
            if (!busy_o && busy_drop < 0) busy_drop = j;
        end
        chk("a5_bits",   {22'd0, samp}, {22'd0, exp_a5});
        chk("busy_drop", busy_drop, 41);

        // ---- burst fill, overflow, clear priority ----
        for (int i = 0; i < 9; i++) begin
            step(vt[i].wr, vt[i].d, vt[i].clr);
            chk($sformatf("vec%0d_count", i), {29'd0, count_o},    {29'd0, vt[i].cnt});
            chk($sformatf("vec%0d_full", i),  {31'd0, full_o},     {31'd0, vt[i].full});
            chk($sformatf("vec%0d_ovf", i),   {31'd0, overflow_o}, {31'd0, vt[i].ovf});
        end
        drain(400);

        // ---- write while full on the cycle of the IDLE pop ----
        for (int i = 0; i < 5; i++) step(1'b1, 8'h11 + 8'(i), 1'b0);
        chk("pre_pop_count", {29'd0, count_o}, 32'd4);
        n = 0;
        while (m_active && n < 100) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("pop_wait_bound", {31'd0, m_active}, 32'd0);
        chk("pop_edge_count", {29'd0, count_o}, 32'd4);
        step(1'b1, 8'hEE, 1'b0);
        chk("pop_wr_count", {29'd0, count_o},    32'd3);
        chk("pop_wr_ovf",   {31'd0, overflow_o}, 32'd1);
        drain(400);
        step(1'b0, 8'h00, 1'b1);

        // ---- async reset mid-DATA of 0x00 with two bytes queued ----
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        repeat (12) step(1'b0, 8'h00, 1'b0);
        chk("mid_count", {29'd0, count_o},   32'd2);
        chk("mid_tx",    {31'd0, uart_tx_o}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst_tx",    {31'd0, uart_tx_o}, 32'd1);
        chk("arst_count", {29'd0, count_o},   32'd0);
        chk("arst_busy",  {31'd0, busy_o},    32'd0);
        chk("arst_empty", {31'd0, empty_o},   32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) step(1'b0, 8'h00, 1'b0);

        // ---- randomized traffic against the model ----
        for (int seg = 0; seg < 12; seg++) begin
            case (seg % 3)
                0:       rate = 2;
                1:       rate = 20;
                default: rate = 80;
            endcase
            for (int c = 0; c < 200; c++) begin
                step(($urandom_range(rate - 1) == 0),
                     8'($urandom),
                     ($urandom_range(19) == 0));
            end
        end
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_uart_tx_buffered
`default_nettype wire
